// File: rtl/dds_pkg.sv
// Shared constants for the DDS phase generator: default widths, quadrant
// encoding and the standard audio tone increments.
package dds_pkg;

  localparam int ACC_W_DEF  = 32;
  localparam int LUT_AW_DEF = 8;
  localparam int OUT_W_DEF  = 16;

  // Quadrant taken from the two accumulator MSBs. Odd quadrants read the
  // quarter-wave table backwards; the upper half-cycle is negative.
  typedef enum logic [1:0] {
    QUAD_0 = 2'b00,
    QUAD_1 = 2'b01,
    QUAD_2 = 2'b10,
    QUAD_3 = 2'b11
  } quad_e;

  // Phase increments for a 48 kHz sample rate.
  localparam logic [31:0] INC_500HZ = 32'h02AA_AAAB;
  localparam logic [31:0] INC_1KHZ  = 32'h0555_5555;

endpackage

// File: rtl/dds_phase_gen_if.sv
// Bus between the frequency-select / ROM / I2S side and the phase generator.
interface dds_phase_gen_if
  import dds_pkg::*;
#(
  parameter int ACC_W  = ACC_W_DEF,
  parameter int LUT_AW = LUT_AW_DEF,
  parameter int OUT_W  = OUT_W_DEF
);
  logic [ACC_W-1:0]        inc;
  logic                    sample_en;
  logic [LUT_AW-1:0]       lut_addr;
  logic [OUT_W-2:0]        lut_data;
  logic [ACC_W-1:0]        phase;
  logic                    wrap;
  logic signed [OUT_W-1:0] sample;
  logic                    sample_valid;

  modport master (
    output inc, sample_en, lut_data,
    input  lut_addr, phase, wrap, sample, sample_valid
  );

  modport slave (
    input  inc, sample_en, lut_data,
    output lut_addr, phase, wrap, sample, sample_valid
  );
endinterface

// File: rtl/dds_quad_fold.sv
// Quarter-wave fold (ROM address generation) and sign unfold of the ROM
// magnitude. The half-cycle sign bit rides alongside the ROM access.
module dds_quad_fold
  import dds_pkg::*;
#(
  parameter int LUT_AW = LUT_AW_DEF,
  parameter int OUT_W  = OUT_W_DEF
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    vld_p0,
  input  logic [LUT_AW+1:0]       acc_top_p0,
  input  logic [OUT_W-2:0]        lut_data_p2,
  output logic [LUT_AW-1:0]       lut_addr_p1,
  output logic signed [OUT_W-1:0] sample_p3,
  output logic                    vld_p3
);

  logic vld_p1, vld_p2;
  logic neg_p1, neg_p2;

  // Mirror the table index in odd quadrants so the table is read backwards.
  function automatic logic [LUT_AW-1:0] fold_addr(input logic [LUT_AW+1:0] top);
    quad_e             q;
    logic [LUT_AW-1:0] idx;
    q   = quad_e'(top[LUT_AW+1:LUT_AW]);
    idx = top[LUT_AW-1:0];
    return (q == QUAD_1 || q == QUAD_3) ? ~idx : idx;
  endfunction

  // Magnitude is at most 2^(OUT_W-1)-1, so negation cannot overflow.
  function automatic logic signed [OUT_W-1:0] unfold(input logic neg,
                                                      input logic [OUT_W-2:0] mag);
    logic signed [OUT_W-1:0] m;
    m = signed'({1'b0, mag});
    return neg ? -m : m;
  endfunction

  // p0 -> p1: fold the phase into a ROM address; p1 -> p2: ROM access;
  // p2 -> p3: restore the sign. Valid bits advance every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      vld_p2      <= 1'b0;
      vld_p3      <= 1'b0;
      neg_p1      <= 1'b0;
      neg_p2      <= 1'b0;
      lut_addr_p1 <= '0;
      sample_p3   <= '0;
    end else begin
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
      if (vld_p0) begin
        lut_addr_p1 <= fold_addr(acc_top_p0);
        neg_p1      <= acc_top_p0[LUT_AW+1];
      end
      if (vld_p1) neg_p2 <= neg_p1;
      if (vld_p2) sample_p3 <= unfold(neg_p2, lut_data_p2);
    end
  end

endmodule

// File: rtl/dds_phase_gen.sv
// Phase accumulator with wrap-synchronous increment reload, feeding the
// quarter-wave fold/unfold pipeline. phase is the live accumulator.
module dds_phase_gen
  import dds_pkg::*;
#(
  parameter int ACC_W  = ACC_W_DEF,
  parameter int LUT_AW = LUT_AW_DEF,
  parameter int OUT_W  = OUT_W_DEF
)(
  input  logic clk,
  input  logic rst,
  dds_phase_gen_if.slave bus
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] act_inc;
  logic             wrap_q;
  logic             vld_p0;
  logic [ACC_W:0]   sum_p0;

  // Sum always uses the increment in force before any reload.
  assign sum_p0 = {1'b0, acc} + {1'b0, act_inc};

  // Advance on each sample strobe; pick up a new increment only at wrap, or
  // when none has been loaded yet, so tone changes are phase-continuous.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      act_inc <= '0;
      wrap_q  <= 1'b0;
      vld_p0  <= 1'b0;
    end else begin
      vld_p0 <= bus.sample_en;
      wrap_q <= 1'b0;
      if (bus.sample_en) begin
        acc    <= sum_p0[ACC_W-1:0];
        wrap_q <= sum_p0[ACC_W];
        if (sum_p0[ACC_W] || act_inc == '0) act_inc <= bus.inc;
      end
    end
  end

  assign bus.phase = acc;
  assign bus.wrap  = wrap_q;

  dds_quad_fold #(
    .LUT_AW (LUT_AW),
    .OUT_W  (OUT_W)
  ) u_fold (
    .clk         (clk),
    .rst         (rst),
    .vld_p0      (vld_p0),
    .acc_top_p0  (acc[ACC_W-1 -: LUT_AW+2]),
    .lut_data_p2 (bus.lut_data),
    .lut_addr_p1 (bus.lut_addr),
    .sample_p3   (bus.sample),
    .vld_p3      (bus.sample_valid)
  );

endmodule

// File: tb/tb_dds_phase_gen.sv
// Self-checking bench for dds_phase_gen with a registered sine ROM model.
module tb_dds_phase_gen;
  import dds_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dds_phase_gen_if #(.ACC_W(32), .LUT_AW(8), .OUT_W(16)) bus ();

  dds_phase_gen #(.ACC_W(32), .LUT_AW(8), .OUT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Registered quarter-wave ROM: data valid one cycle after the address.
  logic [14:0] rom [256];
  always @(posedge clk) bus.lut_data <= rom[bus.lut_addr];

  int vectors     = 0;
  int miscompares = 0;

  // Reference state: phase and the increment currently in force.
  logic [31:0] m_acc = '0;
  logic [31:0] m_act = '0;

  // Expected signed sample for a phase, from the quarter-wave symmetry of sine.
  function automatic logic signed [15:0] exp_sample(input logic [31:0] ph);
    int q, idx, a, mag;
    q   = int'(ph[31:30]);
    idx = int'(ph[29:22]);
    a   = (q % 2 == 1) ? 255 - idx : idx;
    mag = int'(rom[a]);
    return (q >= 2) ? 16'(-mag) : 16'(mag);
  endfunction

  // One sample step of the reference: modular add, carry means wrap, reload
  // the increment at wrap or when none is in force.
  task automatic model_step(input logic [31:0] v, output logic [31:0] eph,
                            output logic ew);
    longint unsigned s;
    s  = longint'(m_acc) + longint'(m_act);
    ew = (s >= 64'h1_0000_0000);
    if (ew || m_act == 0) m_act = v;
    m_acc = s[31:0];
    eph   = m_acc;
  endtask

  // Single sample strobe; returns just after the sampling edge.
  task automatic fire(input logic [31:0] v, output logic [31:0] eph,
                      output logic ew);
    @(negedge clk);
    bus.inc       = v;
    bus.sample_en = 1'b1;
    model_step(v, eph, ew);
    @(posedge clk);
    #1;
    bus.sample_en = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    bus.sample_en = 1'b0;
    bus.inc = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_acc = '0;
    m_act = '0;
  endtask

  task automatic test_reset_and_startup;
    logic [31:0] eph, want;
    logic ew;
    do_reset();
    #1;
    vectors++;
    if (bus.phase !== 32'h0 || bus.wrap !== 1'b0 || bus.lut_addr !== 8'h0 ||
        bus.sample !== 16'sh0 || bus.sample_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: phase=%h wrap=%b addr=%h sample=%h valid=%b, want all 0",
               bus.phase, bus.wrap, bus.lut_addr, bus.sample, bus.sample_valid);
    end
    for (int k = 1; k <= 12; k++) begin
      fire(INC_1KHZ, eph, ew);
      want = 32'(k - 1) * INC_1KHZ;
      vectors++;
      if (bus.phase !== want || bus.wrap !== 1'b0) begin
        miscompares++;
        $display("FAIL startup_phase k=%0d: got %h wrap=%b, want %h wrap=0",
                 k, bus.phase, bus.wrap, want);
      end
      for (int c = 1; c <= 3; c++) begin
        @(posedge clk);
        #1;
        vectors++;
        if (bus.sample_valid !== (c == 3)) begin
          miscompares++;
          $display("FAIL startup_latency k=%0d cyc=%0d: valid=%b, want %b",
                   k, c, bus.sample_valid, (c == 3));
        end
      end
      vectors++;
      if (bus.sample !== exp_sample(want)) begin
        miscompares++;
        $display("FAIL startup_sample k=%0d: got %h, want %h", k, bus.sample, exp_sample(want));
      end
    end
  endtask

  task automatic test_change_at_wrap;
    logic [31:0] eph, want;
    logic ew;
    do_reset();
    for (int k = 1; k <= 54; k++) begin
      fire((k >= 10) ? INC_500HZ : INC_1KHZ, eph, ew);
      if (k <= 50) want = 32'(k - 1) * INC_1KHZ;
      else         want = 32'h0555_5545 + 32'(k - 50) * INC_500HZ;
      vectors++;
      if (bus.phase !== want || bus.wrap !== (k == 50)) begin
        miscompares++;
        $display("FAIL change_at_wrap k=%0d: got %h wrap=%b, want %h wrap=%b",
                 k, bus.phase, bus.wrap, want, (k == 50));
      end
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (bus.sample_valid !== 1'b1 || bus.sample !== exp_sample(want)) begin
        miscompares++;
        $display("FAIL change_sample k=%0d: valid=%b got %h, want 1 %h",
                 k, bus.sample_valid, bus.sample, exp_sample(want));
      end
    end
  endtask

  task automatic test_quadrant_fold;
    logic [31:0] eph;
    logic ew;
    logic [7:0] want_addr;
    logic signed [15:0] want_s;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      fire(32'h4000_0000, eph, ew);
      @(posedge clk);
      #1;
      want_addr = (k % 2 == 1) ? 8'd255 : 8'd0;
      vectors++;
      if (bus.lut_addr !== want_addr) begin
        miscompares++;
        $display("FAIL quad_addr q=%0d: got %0d, want %0d", k, bus.lut_addr, want_addr);
      end
      repeat (2) @(posedge clk);
      #1;
      want_s = (k < 2) ? 16'(int'(rom[want_addr])) : 16'(-int'(rom[want_addr]));
      vectors++;
      if (bus.sample_valid !== 1'b1 || bus.sample !== want_s) begin
        miscompares++;
        $display("FAIL quad_sample q=%0d: valid=%b got %0d, want %0d",
                 k, bus.sample_valid, bus.sample, want_s);
      end
    end
  endtask

  task automatic test_simul_wrap;
    logic [31:0] eph;
    logic ew;
    do_reset();
    fire(32'h8000_0000, eph, ew);
    fire(32'h8000_0000, eph, ew);
    fire(32'h1234_5678, eph, ew);
    vectors++;
    if (bus.phase !== 32'h0 || bus.wrap !== 1'b1) begin
      miscompares++;
      $display("FAIL simul_wrap: got %h wrap=%b, want 0 wrap=1", bus.phase, bus.wrap);
    end
    fire(32'h1111_1111, eph, ew);
    vectors++;
    if (bus.phase !== 32'h1234_5678 || bus.wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL simul_reload: got %h wrap=%b, want 12345678 wrap=0", bus.phase, bus.wrap);
    end
    repeat (4) @(posedge clk);
  endtask

  task automatic test_reset_mid;
    logic [31:0] eph;
    logic ew;
    do_reset();
    fire(INC_1KHZ, eph, ew);
    fire(INC_1KHZ, eph, ew);
    repeat (4) @(posedge clk);
    fire(INC_1KHZ, eph, ew);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (bus.sample_valid !== 1'b0 || bus.phase !== 32'h0 ||
          bus.lut_addr !== 8'h0 || bus.sample !== 16'sh0) begin
        miscompares++;
        $display("FAIL reset_mid cyc=%0d: valid=%b phase=%h addr=%h sample=%h, want all 0",
                 c, bus.sample_valid, bus.phase, bus.lut_addr, bus.sample);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    m_acc = '0;
    m_act = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (bus.sample_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_idle: valid=%b, want 0", bus.sample_valid);
    end
    fire(INC_500HZ, eph, ew);
    fire(INC_1KHZ, eph, ew);
    vectors++;
    if (bus.phase !== INC_500HZ) begin
      miscompares++;
      $display("FAIL reset_mid_reload: got %h, want %h", bus.phase, INC_500HZ);
    end
    repeat (4) @(posedge clk);
  endtask

  task automatic test_zero_inc;
    logic [31:0] eph;
    logic ew;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      fire(32'h0, eph, ew);
      vectors++;
      if (bus.phase !== 32'h0 || bus.wrap !== 1'b0) begin
        miscompares++;
        $display("FAIL zero_inc k=%0d: got %h wrap=%b, want 0 wrap=0", k, bus.phase, bus.wrap);
      end
    end
    fire(32'h0001_0000, eph, ew);
    vectors++;
    if (bus.phase !== 32'h0) begin
      miscompares++;
      $display("FAIL zero_load: got %h, want 0", bus.phase);
    end
    fire(32'h0001_0000, eph, ew);
    vectors++;
    if (bus.phase !== 32'h0001_0000) begin
      miscompares++;
      $display("FAIL zero_step: got %h, want 00010000", bus.phase);
    end
    repeat (4) @(posedge clk);
  endtask

  task automatic test_back_to_back;
    localparam int N = 200;
    logic hist_en [N+3];
    logic signed [15:0] hist_s [N+3];
    logic [31:0] eph;
    logic ew, en, exp_v;
    do_reset();
    bus.inc = $urandom;
    for (int t = 0; t < N + 3; t++) begin
      @(negedge clk);
      en = (t < N) && ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) bus.inc = $urandom;
      bus.sample_en = en;
      ew = 1'b0;
      if (en) model_step(bus.inc, eph, ew);
      hist_en[t] = en;
      hist_s[t]  = exp_sample(m_acc);
      @(posedge clk);
      #1;
      vectors++;
      if (bus.phase !== m_acc || bus.wrap !== ew) begin
        miscompares++;
        $display("FAIL b2b_phase t=%0d: got %h wrap=%b, want %h wrap=%b",
                 t, bus.phase, bus.wrap, m_acc, ew);
      end
      exp_v = (t >= 3) ? hist_en[t-3] : 1'b0;
      vectors++;
      if (bus.sample_valid !== exp_v || (exp_v && bus.sample !== hist_s[t-3])) begin
        miscompares++;
        $display("FAIL b2b_sample t=%0d: valid=%b got %h, want %b %h", t,
                 bus.sample_valid, bus.sample, exp_v, (t >= 3) ? hist_s[t-3] : 16'sh0);
      end
    end
    bus.sample_en = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < 256; a++)
      rom[a] = 15'($rtoi($floor($sin((a + 0.5) * 3.14159265358979 / 512.0) * 32767.0 + 0.5)));
    bus.inc = '0;
    bus.sample_en = 1'b0;
    test_reset_and_startup();
    test_change_at_wrap();
    test_quadrant_fold();
    test_simul_wrap();
    test_reset_mid();
    test_zero_inc();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
